multiplier_unit_cu: RTL and testbench
=====================================

Name: multiplier_unit_cu

Overview:
Control unit that sequences the 32-bit carry-save radix-2 multiplier datapath. It accepts a start request and drives the datapath's register enables, mux selects and counter enable through clear, load, first-partial-product, iterate and writeback phases. It returns busy/done status to the requester, supports an abort, and runs a watchdog on the datapath terminal count. It sits beside the multiplier datapath inside the multiply/divide unit, one controller per datapath.

Parameters:
PARALLELISM, 32, operand width; the expected ITER length is PARALLELISM cycles.
WD_WIDTH, 6, width of the internal watchdog counter; must satisfy 2^WD_WIDTH > PARALLELISM.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a multiply; honoured only while ready=1
abort  in  1  synchronous abort; returns the controller to IDLE
tc  in  1  datapath counter terminal count
ready  out  1  high in IDLE only
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; product register valid
wd_err  out  1  sticky watchdog error; cleared by the next accepted start
operand_hold  out  1  high in CLEAR, LOAD and INIT; operands and usigned must be stable while high
csa_clear  out  1  clear the datapath CSA and operand registers
multiplicand_en  out  1  multiplicand register enable
notMultiplicand_en  out  1  negated-multiplicand register enable
sumMux_sel  out  1  0 = first partial product, 1 = CSA feedback
sum_en  out  1  sum register enables
carry_en  out  1  carry register enable
leftAddMux_sel  out  1  0 = negate-multiplicand path, 1 = final carry-propagate add
count_en  out  1  datapath counter enable
prod_en  out  1  product register enable

Behaviour:
- Moore FSM with registered state; every datapath control is a pure decode of the state. Undefined state encodings go to IDLE.
- Reset (asynchronous, rst_n=0): state=IDLE, watchdog counter=0, wd_err=0. Outputs at reset: ready=1; every other output 0.
- IDLE: ready=1, all controls 0. start=1 -> CLEAR.
- CLEAR (1 cycle): csa_clear=1 -> LOAD.
- LOAD (1 cycle): multiplicand_en=1, notMultiplicand_en=1, leftAddMux_sel=0 -> INIT.
- INIT (1 cycle): sum_en=1, sumMux_sel=0, leftAddMux_sel=0; carry_en=0 -> ITER. The watchdog counter is cleared in this cycle.
- ITER: sum_en=1, carry_en=1, count_en=1, sumMux_sel=1, leftAddMux_sel=1.
  - Watchdog counter increments each ITER cycle.
  - tc=1 sampled in ITER -> FINAL; that cycle's count still applies.
  - If the watchdog counter reaches PARALLELISM with tc=0 -> set wd_err, go to FINAL.
  - If tc=1 and the watchdog limit occur in the same cycle, tc wins and wd_err stays 0.
- FINAL (1 cycle): leftAddMux_sel=1, prod_en=1, all other enables 0 -> DONE.
- DONE (1 cycle): done=1 -> IDLE. start is not accepted in DONE; it must be re-asserted in IDLE.
- Latency: start sampled at edge 0 -> CLEAR in cycle 1, LOAD 2, INIT 3, ITER 4..35 (32 cycles at default), FINAL 36, done=1 in cycle 37. Throughput is one product per 38 cycles.
- The datapath counter returns to 0 after its terminal count. The controller never clears that counter, so ITER must be entered only with the counter at 0. Abort violates this; see the abort rules.
- abort=1 in any non-IDLE state:
  - next state is CLEAR_ABORT (1 cycle, csa_clear=1), then IDLE.
  - No done pulse; prod_en is never asserted after the abort.
  - If the abort occurs during ITER, CLEAR_ABORT also asserts count_en until tc is observed, realigning the datapath counter to 0. CLEAR_ABORT therefore lasts until tc=1, bounded by the watchdog.
- abort in IDLE is ignored. start together with abort in IDLE: abort wins and the start is dropped.
- start while busy=1 is ignored; no queuing.
- wd_err clears on the cycle a new start is accepted.

Test Plan:
- Reset mid-ITER (rst_n low at cycle 20) -> all controls 0, ready=1, busy=0 immediately (asynchronous); a fresh start afterwards gives done at cycle 37.
- Single start, tc model high on the 32nd ITER cycle -> states CLEAR, LOAD, INIT, ITER×32, FINAL, DONE; prod_en exactly in cycle 36; done exactly in cycle 37; with 0xFFFFFFFF × 0x00000003 unsigned, the datapath product is 0x00000002FFFFFFFD.
- Back-to-back start held high continuously -> the second operation starts in the IDLE cycle after DONE (cycle 38); second done at cycle 75.
- abort at ITER cycle 10 -> no prod_en and no done; csa_clear high; count_en continues until tc; the next operation completes with the correct product 7 × -5 = -35 signed (0xFFFFFFFFFFFFFFDD).
- tc stuck at 0 -> wd_err=1 after 32 ITER cycles; FINAL and DONE still occur; the next accepted start clears wd_err.
- start pulsed during INIT and during DONE -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/multiplier_unit_cu_if.sv
// Request/status and datapath-control bundle between the multiplier control unit,
// its requester and the carry-save multiplier datapath.
interface multiplier_unit_cu_if;
  logic start;
  logic abort;
  logic tc;
  logic ready;
  logic busy;
  logic done;
  logic wd_err;
  logic operand_hold;
  logic csa_clear;
  logic multiplicand_en;
  logic notMultiplicand_en;
  logic sumMux_sel;
  logic sum_en;
  logic carry_en;
  logic leftAddMux_sel;
  logic count_en;
  logic prod_en;

  // master: requester plus datapath side; slave: the control unit
  modport master (
    output start, abort, tc,
    input  ready, busy, done, wd_err, operand_hold, csa_clear, multiplicand_en,
           notMultiplicand_en, sumMux_sel, sum_en, carry_en, leftAddMux_sel,
           count_en, prod_en
  );

  modport slave (
    input  start, abort, tc,
    output ready, busy, done, wd_err, operand_hold, csa_clear, multiplicand_en,
           notMultiplicand_en, sumMux_sel, sum_en, carry_en, leftAddMux_sel,
           count_en, prod_en
  );
endinterface

// File: rtl/multiplier_unit_cu.sv
// Moore control unit sequencing the radix-2 carry-save multiplier datapath:
// clear, load, first partial product, iterate, final add and done, with abort and watchdog.
module multiplier_unit_cu #(
  parameter int PARALLELISM = 32,
  parameter int WD_WIDTH    = 6
) (
  input logic                 clk,
  input logic                 rst_n,
  multiplier_unit_cu_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE             = 4'd0,
    CLEAR            = 4'd1,
    LOAD             = 4'd2,
    INIT             = 4'd3,
    ITER             = 4'd4,
    FINAL            = 4'd5,
    DONE             = 4'd6,
    CLEAR_ABORT      = 4'd7,
    CLEAR_ABORT_ITER = 4'd8
  } state_t;

  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(PARALLELISM - 1);

  state_t              state_reg, state_next;
  logic [WD_WIDTH-1:0] wd_cnt_reg, wd_cnt_next;
  logic                wd_err_reg, wd_err_next;
  logic                wd_limit;

  // The count taken in the current cycle is the PARALLELISM-th one
  assign wd_limit = (wd_cnt_reg >= WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      wd_cnt_reg <= '0;
      wd_err_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wd_cnt_reg <= wd_cnt_next;
      wd_err_reg <= wd_err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wd_cnt_next = wd_cnt_reg;
    wd_err_next = wd_err_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next  = CLEAR;
          wd_err_next = 1'b0;
        end
      end
      CLEAR: state_next = LOAD;
      LOAD:  state_next = INIT;
      INIT: begin
        wd_cnt_next = '0;
        state_next  = ITER;
      end
      ITER: begin
        wd_cnt_next = wd_cnt_reg + WD_WIDTH'(1);
        if (bus.abort) begin
          // A tc in this cycle already wrapped the datapath counter to 0
          state_next = bus.tc ? CLEAR_ABORT : CLEAR_ABORT_ITER;
        end else if (bus.tc) begin
          state_next = FINAL;
        end else if (wd_limit) begin
          state_next  = FINAL;
          wd_err_next = 1'b1;
        end
      end
      FINAL:       state_next = DONE;
      DONE:        state_next = IDLE;
      CLEAR_ABORT: state_next = IDLE;
      CLEAR_ABORT_ITER: begin
        // Keep stepping the datapath counter until it wraps back to 0
        wd_cnt_next = wd_cnt_reg + WD_WIDTH'(1);
        if (bus.tc) begin
          state_next = IDLE;
        end else if (wd_limit) begin
          state_next  = IDLE;
          wd_err_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (bus.abort && (state_reg inside {CLEAR, LOAD, INIT, FINAL, DONE, CLEAR_ABORT})) begin
      state_next = CLEAR_ABORT;
    end
  end

  always_comb begin
    bus.ready              = 1'b0;
    bus.busy               = (state_reg != IDLE);
    bus.done               = 1'b0;
    bus.wd_err             = wd_err_reg;
    bus.operand_hold       = 1'b0;
    bus.csa_clear          = 1'b0;
    bus.multiplicand_en    = 1'b0;
    bus.notMultiplicand_en = 1'b0;
    bus.sumMux_sel         = 1'b0;
    bus.sum_en             = 1'b0;
    bus.carry_en           = 1'b0;
    bus.leftAddMux_sel     = 1'b0;
    bus.count_en           = 1'b0;
    bus.prod_en            = 1'b0;
    case (state_reg)
      IDLE: bus.ready = 1'b1;
      CLEAR: begin
        bus.csa_clear    = 1'b1;
        bus.operand_hold = 1'b1;
      end
      LOAD: begin
        bus.multiplicand_en    = 1'b1;
        bus.notMultiplicand_en = 1'b1;
        bus.operand_hold       = 1'b1;
      end
      INIT: begin
        bus.sum_en       = 1'b1;
        bus.operand_hold = 1'b1;
      end
      ITER: begin
        bus.sum_en         = 1'b1;
        bus.carry_en       = 1'b1;
        bus.count_en       = 1'b1;
        bus.sumMux_sel     = 1'b1;
        bus.leftAddMux_sel = 1'b1;
      end
      FINAL: begin
        bus.leftAddMux_sel = 1'b1;
        bus.prod_en        = 1'b1;
      end
      DONE:        bus.done = 1'b1;
      CLEAR_ABORT: bus.csa_clear = 1'b1;
      CLEAR_ABORT_ITER: begin
        bus.csa_clear = 1'b1;
        bus.count_en  = 1'b1;
      end
      default: bus.ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multiplier_unit_cu.sv
// Bench for multiplier_unit_cu: a behavioural shift-add datapath follows the controls,
// and a scoreboard checks product, wd_err and done timing for each accepted start.
module tb_multiplier_unit_cu;
  localparam int P = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        stuck;
    logic [63:0] prod;
    logic        wd;
  } vec_t;

  typedef struct {
    logic [63:0] prod;
    logic        wd;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  multiplier_unit_cu_if bus();

  multiplier_unit_cu #(.PARALLELISM(P), .WD_WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural datapath driven by the controller
  logic [31:0] op_a, op_b;
  logic        op_signed;
  logic        tc_stuck;
  logic [4:0]  dp_cnt;
  logic [63:0] mc, acc, prod;

  assign bus.tc = tc_stuck ? 1'b0 : (dp_cnt == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_cnt <= '0;
      mc     <= '0;
      acc    <= '0;
      prod   <= '0;
    end else begin
      if (bus.count_en) dp_cnt <= dp_cnt + 5'd1;
      if (bus.csa_clear) mc <= '0;
      else if (bus.multiplicand_en) mc <= op_signed ? {{32{op_a[31]}}, op_a} : {32'b0, op_a};
      if (bus.csa_clear) acc <= '0;
      else if (bus.sum_en && !bus.sumMux_sel) acc <= '0;
      else if (bus.sum_en && bus.sumMux_sel && bus.carry_en && op_b[dp_cnt])
        acc <= (op_signed && dp_cnt == 5'd31) ? acc - (mc << dp_cnt) : acc + (mc << dp_cnt);
      if (bus.prod_en) prod <= acc;
    end
  end

  wire [11:0] ctrl_vec = {bus.done, bus.wd_err, bus.operand_hold, bus.csa_clear,
                          bus.multiplicand_en, bus.notMultiplicand_en, bus.sumMux_sel,
                          bus.sum_en, bus.carry_en, bus.leftAddMux_sel, bus.count_en,
                          bus.prod_en};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: one entry per accepted start, retired on done
  exp_t sb_q[$];
  int   prod_en_cyc = -1;
  int   done_cnt = 0;
  logic prod_forbid = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.prod_en) begin
        prod_en_cyc = cyc;
        if (prod_forbid) check("prod_en_after_abort", 64'(bus.prod_en), 64'(0));
      end
      if (bus.done) begin
        exp_t e;
        done_cnt++;
        check("done_has_pending_op", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("product", prod, e.prod);
          check("wd_err_at_done", 64'(bus.wd_err), 64'(e.wd));
          check("done_cycle", 64'(cyc), 64'(e.due));
          check("prod_en_cycle", 64'(prod_en_cyc), 64'(cyc - 1));
          $display("op done: cycle %0d product 0x%016h wd_err %0b", cyc, prod, bus.wd_err);
        end
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_start", 64'(bus.ready), 64'(1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 120) begin
      @(negedge clk);
      n++;
    end
    check("op_completed", 64'(sb_q.size() == 0), 64'(1));
    sb_q.delete();
  endtask

  task automatic run_op(input vec_t v, input logic prev_wd);
    exp_t e;
    op_a = v.a; op_b = v.b; op_signed = v.sgn; tc_stuck = v.stuck;
    wait_ready();
    check("wd_err_sticky_in_idle", 64'(bus.wd_err), 64'(prev_wd));
    bus.start = 1'b1;
    e.prod = v.prod; e.wd = v.wd; e.due = cyc + 1 + 36;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'(1));
    check("wd_err_cleared_on_start", 64'(bus.wd_err), 64'(0));
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  vec_t vecs[8];

  initial begin
    int   c, e0, n, dones_before;
    logic prev_wd;
    exp_t ex;

    vecs[0] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0003, sgn: 1'b0, stuck: 1'b0, prod: 64'h0000_0002_FFFF_FFFD, wd: 1'b0};
    vecs[1] = '{a: 32'h0000_0007, b: 32'hFFFF_FFFB, sgn: 1'b1, stuck: 1'b0, prod: 64'hFFFF_FFFF_FFFF_FFDD, wd: 1'b0};
    vecs[2] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, sgn: 1'b0, stuck: 1'b0, prod: 64'hFFFF_FFFE_0000_0001, wd: 1'b0};
    vecs[3] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, sgn: 1'b1, stuck: 1'b0, prod: 64'h0000_0000_0000_0001, wd: 1'b0};
    vecs[4] = '{a: 32'h8000_0000, b: 32'h8000_0000, sgn: 1'b1, stuck: 1'b0, prod: 64'h4000_0000_0000_0000, wd: 1'b0};
    vecs[5] = '{a: 32'h0000_0005, b: 32'h0000_0006, sgn: 1'b0, stuck: 1'b1, prod: 64'h0000_0000_0000_001E, wd: 1'b1};
    vecs[6] = '{a: 32'h1234_5678, b: 32'h0000_0001, sgn: 1'b0, stuck: 1'b0, prod: 64'h0000_0000_1234_5678, wd: 1'b0};
    vecs[7] = '{a: 32'h0000_0000, b: 32'hDEAD_BEEF, sgn: 1'b0, stuck: 1'b0, prod: 64'h0000_0000_0000_0000, wd: 1'b0};

    bus.start = 1'b0; bus.abort = 1'b0;
    op_a = '0; op_b = '0; op_signed = 1'b0; tc_stuck = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(bus.ready), 64'(1));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_controls", 64'(ctrl_vec), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven operations
    prev_wd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], prev_wd);
      prev_wd = vecs[i].wd;
    end

    // asynchronous reset in the middle of ITER
    op_a = 32'd9; op_b = 32'd9; op_signed = 1'b0; tc_stuck = 1'b0;
    wait_ready();
    c = cyc; bus.start = 1'b1; e0 = c + 1;
    @(negedge clk); bus.start = 1'b0;
    wait_until(e0 + 19);
    check("mid_iter_count_en", 64'(bus.count_en), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ready", 64'(bus.ready), 64'(1));
    check("async_reset_busy", 64'(bus.busy), 64'(0));
    check("async_reset_controls", 64'(ctrl_vec), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_op(vecs[0], 1'b0);

    // start and abort together in IDLE: abort wins
    wait_ready();
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("idle_abort_drops_start", 64'(bus.busy), 64'(0));

    // back-to-back with start held high
    op_a = 32'h0001_0000; op_b = 32'h0001_0000; op_signed = 1'b0; tc_stuck = 1'b0;
    wait_ready();
    c = cyc; e0 = c + 1; bus.start = 1'b1;
    ex.prod = 64'h0000_0001_0000_0000; ex.wd = 1'b0;
    ex.due = e0 + 36; sb_q.push_back(ex);
    ex.due = e0 + 74; sb_q.push_back(ex);
    wait_until(e0 + 37);
    check("b2b_idle_after_done", 64'(bus.ready), 64'(1));
    wait_until(e0 + 38);
    check("b2b_second_accepted", 64'(bus.csa_clear), 64'(1));
    bus.start = 1'b0;
    wait_drain();

    // abort at ITER cycle 10, then realignment until tc
    op_a = 32'd3; op_b = 32'd4; op_signed = 1'b0; tc_stuck = 1'b0;
    wait_ready();
    c = cyc; e0 = c + 1; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    dones_before = done_cnt;
    prod_forbid = 1'b1;
    wait_until(e0 + 12);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_csa_clear", 64'(bus.csa_clear), 64'(1));
    check("abort_count_en", 64'(bus.count_en), 64'(1));
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("abort_realign_cycles", 64'(n), 64'(22));
    check("abort_counter_realigned", 64'(dp_cnt), 64'(0));
    check("abort_no_done", 64'(done_cnt), 64'(dones_before));
    prod_forbid = 1'b0;
    run_op(vecs[1], 1'b0);

    // start pulses during INIT and DONE are ignored
    op_a = 32'd11; op_b = 32'd13; op_signed = 1'b0; tc_stuck = 1'b0;
    wait_ready();
    c = cyc; e0 = c + 1; bus.start = 1'b1;
    ex.prod = 64'd143; ex.wd = 1'b0; ex.due = e0 + 36; sb_q.push_back(ex);
    dones_before = done_cnt;
    @(negedge clk); bus.start = 1'b0;
    wait_until(e0 + 2);
    check("init_operand_hold", 64'(bus.operand_hold), 64'(1));
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    wait_until(e0 + 36);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check("done_start_not_taken", 64'(bus.ready), 64'(1));
    @(negedge clk);
    check("idle_after_ignored_start", 64'(bus.busy), 64'(0));
    repeat (45) @(negedge clk);
    check("one_done_per_start", 64'(done_cnt), 64'(dones_before + 1));
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
